// File: rtl/mac_tile_mem_if.sv
// mac_tile_mem_if: bundles the load, element-read, C-write and C-drain
// signals of mac_tile_mem. The slave modport is the memory; the master
// modport is the host/DMA + MAC-array side that drives it.
interface mac_tile_mem_if #(
   parameter int P_M    = 4,
   parameter int P_K    = 4,
   parameter int P_N    = 4,
   parameter int DW_IN  = 8,
   parameter int DW_OUT = 2*DW_IN
);
   localparam int AW = (P_M*P_K > 1) ? $clog2(P_M*P_K) : 1;
   localparam int BW = (P_K*P_N > 1) ? $clog2(P_K*P_N) : 1;
   localparam int CW = (P_M*P_N > 1) ? $clog2(P_M*P_N) : 1;

   logic                     ld_valid;
   logic                     ld_ready;
   logic [P_M*P_K*DW_IN-1:0] ld_a;
   logic [P_K*P_N*DW_IN-1:0] ld_b;
   logic                     act_valid;
   logic                     rd_req;
   logic [AW-1:0]            rd_a_addr;
   logic [BW-1:0]            rd_b_addr;
   logic                     rd_valid;
   logic [DW_IN-1:0]         rd_a;
   logic [DW_IN-1:0]         rd_b;
   logic                     rd_release;
   logic                     c_we;
   logic [CW-1:0]            c_addr;
   logic [DW_OUT-1:0]        c_data;
   logic                     c_drain_start;
   logic                     c_busy;
   logic                     c_out_valid;
   logic                     c_out_ready;
   logic [DW_OUT-1:0]        c_out_data;
   logic [CW-1:0]            c_out_idx;
   logic                     c_out_last;

   modport slave (
      input  ld_valid, ld_a, ld_b, rd_req, rd_a_addr, rd_b_addr, rd_release,
             c_we, c_addr, c_data, c_drain_start, c_out_ready,
      output ld_ready, act_valid, rd_valid, rd_a, rd_b,
             c_busy, c_out_valid, c_out_data, c_out_idx, c_out_last
   );

   modport master (
      output ld_valid, ld_a, ld_b, rd_req, rd_a_addr, rd_b_addr, rd_release,
             c_we, c_addr, c_data, c_drain_start, c_out_ready,
      input  ld_ready, act_valid, rd_valid, rd_a, rd_b,
             c_busy, c_out_valid, c_out_data, c_out_idx, c_out_last
   );
endinterface

// File: rtl/mac_tile_mem.sv
// mac_tile_mem: ping-pong A/B operand store plus C result store for the
// MAC datapath. Two operand banks let tile n+1 load while tile n is read;
// C is written element-wise and streamed out one element per beat.
// Optional feature: define MAC_TILE_MEM_C_ACCUM_EN to make c_we accumulate
// into C and to clear each C element as it is drained.
module mac_tile_mem #(
   parameter int P_M    = 4,
   parameter int P_K    = 4,
   parameter int P_N    = 4,
   parameter int DW_IN  = 8,
   parameter int DW_OUT = 2*DW_IN
) (
   input logic            clk,
   input logic            rstn,
   mac_tile_mem_if.slave  bus
);
   localparam int NA = P_M*P_K;
   localparam int NB = P_K*P_N;
   localparam int NC = P_M*P_N;
   localparam int CW = (NC > 1) ? $clog2(NC) : 1;

   typedef enum logic {IDLE, DRAIN} drain_state_t;

   logic [DW_IN-1:0]  bank_a [2][NA];
   logic [DW_IN-1:0]  bank_b [2][NB];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        full_cnt;
   logic              ld_fire;
   logic              rel_fire;
   logic              rd_fire;

   logic [DW_OUT-1:0] c_mem [NC];
   drain_state_t      state;
   logic [CW-1:0]     c_next_idx;
   logic              c_wr_ok;
   logic              c_hs;

   assign bus.ld_ready  = (full_cnt < 2'd2);
   assign bus.act_valid = (full_cnt != 2'd0);
   assign ld_fire    = bus.ld_valid && bus.ld_ready;
   assign rel_fire   = bus.rd_release && bus.act_valid;
   assign rd_fire    = bus.rd_req && bus.act_valid;

   assign c_next_idx = bus.c_out_idx + CW'(1);
   assign c_wr_ok    = bus.c_we && (int'(bus.c_addr) < NC);
   assign c_hs       = bus.c_out_valid && bus.c_out_ready;

   // Operand banks, bank pointers, occupancy and the 1-cycle read port.
   // A read issued together with a release still sees the bank being released.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NA; i++) bank_a[b][i] <= '0;
            for (int i = 0; i < NB; i++) bank_b[b][i] <= '0;
         end
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         full_cnt     <= 2'd0;
         bus.rd_valid <= 1'b0;
         bus.rd_a     <= '0;
         bus.rd_b     <= '0;
      end else begin
         if (ld_fire) begin
            for (int i = 0; i < NA; i++) bank_a[wr_ptr][i] <= bus.ld_a[i*DW_IN +: DW_IN];
            for (int i = 0; i < NB; i++) bank_b[wr_ptr][i] <= bus.ld_b[i*DW_IN +: DW_IN];
            wr_ptr <= ~wr_ptr;
         end
         if (rel_fire) rd_ptr <= ~rd_ptr;
         case ({ld_fire, rel_fire})
            2'b10:   full_cnt <= full_cnt + 2'd1;
            2'b01:   full_cnt <= full_cnt - 2'd1;
            default: full_cnt <= full_cnt;
         endcase
         bus.rd_valid <= rd_fire;
         if (rd_fire) begin
            bus.rd_a <= (int'(bus.rd_a_addr) < NA) ? bank_a[rd_ptr][bus.rd_a_addr] : '0;
            bus.rd_b <= (int'(bus.rd_b_addr) < NB) ? bank_b[rd_ptr][bus.rd_b_addr] : '0;
         end
      end
   end

   // C store and drain FSM; outputs are registered and C writes are only
   // accepted while idle, so the element being streamed cannot change under us.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NC; i++) c_mem[i] <= '0;
         state           <= IDLE;
         bus.c_busy      <= 1'b0;
         bus.c_out_valid <= 1'b0;
         bus.c_out_data  <= '0;
         bus.c_out_idx   <= '0;
         bus.c_out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (c_wr_ok) begin
`ifdef MAC_TILE_MEM_C_ACCUM_EN
                  c_mem[bus.c_addr] <= c_mem[bus.c_addr] + bus.c_data;
`else
                  c_mem[bus.c_addr] <= bus.c_data;
`endif
               end
               if (bus.c_drain_start) begin
                  state           <= DRAIN;
                  bus.c_busy      <= 1'b1;
                  bus.c_out_valid <= 1'b1;
                  bus.c_out_idx   <= '0;
                  bus.c_out_data  <= c_mem[0];
                  bus.c_out_last  <= (NC == 1);
               end
            end
            DRAIN: begin
               if (c_hs) begin
`ifdef MAC_TILE_MEM_C_ACCUM_EN
                  c_mem[bus.c_out_idx] <= '0;
`endif
                  if (bus.c_out_last) begin
                     state           <= IDLE;
                     bus.c_busy      <= 1'b0;
                     bus.c_out_valid <= 1'b0;
                     bus.c_out_last  <= 1'b0;
                  end else begin
                     bus.c_out_idx  <= c_next_idx;
                     bus.c_out_data <= c_mem[c_next_idx];
                     bus.c_out_last <= (c_next_idx == CW'(NC-1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_tile_mem.sv
// tb_mac_tile_mem: randomized and directed checks of mac_tile_mem against a
// behavioural model (queue of loaded tiles, plain C array).
module tb_mac_tile_mem;
   localparam int P_M = 4, P_K = 4, P_N = 4, DW_IN = 8, DW_OUT = 16;
   localparam int NA = P_M*P_K, NB = P_K*P_N, NC = P_M*P_N;
   localparam int AW = 4, BW = 4, CW = 4;

`ifdef MAC_TILE_MEM_C_ACCUM_EN
   localparam bit ACCUM = 1'b1;
`else
   localparam bit ACCUM = 1'b0;
`endif

   typedef logic [NA*DW_IN-1:0] tile_a_t;
   typedef logic [NB*DW_IN-1:0] tile_b_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mac_tile_mem_if #(.P_M(P_M), .P_K(P_K), .P_N(P_N), .DW_IN(DW_IN), .DW_OUT(DW_OUT)) bus ();

   mac_tile_mem #(.P_M(P_M), .P_K(P_K), .P_N(P_N), .DW_IN(DW_IN), .DW_OUT(DW_OUT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int compared = 0;
   int mismatched = 0;

   tile_a_t q_a[$];
   tile_b_t q_b[$];
   logic [DW_IN-1:0]  exp_rd_a, exp_rd_b;
   logic [DW_OUT-1:0] c_model [NC];
   logic [DW_OUT-1:0] drained [NC];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      bus.ld_valid = 1'b0; bus.ld_a = '0; bus.ld_b = '0;
      bus.rd_req = 1'b0; bus.rd_a_addr = '0; bus.rd_b_addr = '0; bus.rd_release = 1'b0;
      bus.c_we = 1'b0; bus.c_addr = '0; bus.c_data = '0;
      bus.c_drain_start = 1'b0; bus.c_out_ready = 1'b0;
   endtask

   task automatic clearModel();
      q_a.delete(); q_b.delete();
      exp_rd_a = '0; exp_rd_b = '0;
      for (int i = 0; i < NC; i++) c_model[i] = '0;
   endtask

   task automatic applyReset();
      rstn = 1'b0;
      idleInputs();
      clearModel();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   function automatic tile_a_t randTileA();
      tile_a_t t;
      for (int i = 0; i < NA; i++) t[i*DW_IN +: DW_IN] = DW_IN'($urandom);
      return t;
   endfunction

   function automatic tile_b_t randTileB();
      tile_b_t t;
      for (int i = 0; i < NB; i++) t[i*DW_IN +: DW_IN] = DW_IN'($urandom);
      return t;
   endfunction

   // One cycle of load/read/release traffic, checked against the tile queue.
   task automatic applyStimulus(input bit ldv, input tile_a_t a, input tile_b_t b,
                                input bit rq, input int ra, input int rb, input bit rel);
      bit act, rd_fire, rel_fire, ld_fire;
      tile_a_t ta;
      tile_b_t tb;
      bus.ld_valid = ldv; bus.ld_a = a; bus.ld_b = b;
      bus.rd_req = rq; bus.rd_a_addr = AW'(ra); bus.rd_b_addr = BW'(rb);
      bus.rd_release = rel;
      act      = (q_a.size() > 0);
      rd_fire  = rq && act;
      rel_fire = rel && act;
      ld_fire  = ldv && (q_a.size() < 2);
      if (rd_fire) begin
         ta = q_a[0];
         tb = q_b[0];
         exp_rd_a = (ra < NA) ? ta[ra*DW_IN +: DW_IN] : '0;
         exp_rd_b = (rb < NB) ? tb[rb*DW_IN +: DW_IN] : '0;
      end
      tick();
      if (rel_fire) begin
         void'(q_a.pop_front());
         void'(q_b.pop_front());
      end
      if (ld_fire) begin
         q_a.push_back(a);
         q_b.push_back(b);
      end
      checkOutput("rd_valid", bus.rd_valid, rd_fire);
      checkOutput("rd_a", bus.rd_a, exp_rd_a);
      checkOutput("rd_b", bus.rd_b, exp_rd_b);
      checkOutput("ld_ready", bus.ld_ready, q_a.size() < 2);
      checkOutput("act_valid", bus.act_valid, q_a.size() > 0);
      bus.ld_valid = 1'b0; bus.rd_req = 1'b0; bus.rd_release = 1'b0;
   endtask

   task automatic cWrite(input int addr, input logic [DW_OUT-1:0] data);
      bus.c_we = 1'b1; bus.c_addr = CW'(addr); bus.c_data = data;
      tick();
      if (ACCUM) c_model[addr] = c_model[addr] + data;
      else       c_model[addr] = data;
      bus.c_we = 1'b0;
   endtask

   // ready_mode: 0 always ready, 1 toggles 1,0,..., 2 random.
   // abort_at >= 0 stops (without handshaking) once that index is presented.
   task automatic drainRun(input int ready_mode, input int abort_at, input bit inject_we);
      int idx = 0;
      int cycles = 0;
      bit done = 0;
      bit aborted = 0;
      bit rdy;
      bus.c_drain_start = 1'b1;
      tick();
      bus.c_drain_start = 1'b0;
      checkOutput("c_busy_start", bus.c_busy, 1'b1);
      while (!done && !aborted && cycles < 200) begin
         if (idx == abort_at) begin
            aborted = 1;
         end else begin
            checkOutput("c_out_valid", bus.c_out_valid, 1'b1);
            checkOutput("c_out_idx", bus.c_out_idx, idx);
            checkOutput("c_out_data", bus.c_out_data, c_model[idx]);
            checkOutput("c_out_last", bus.c_out_last, idx == NC-1);
            case (ready_mode)
               0:       rdy = 1'b1;
               1:       rdy = (cycles % 2 == 0);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.c_out_ready = rdy;
            if (inject_we) begin
               bus.c_we   = 1'($urandom_range(0, 1));
               bus.c_addr = CW'($urandom_range(0, NC-1));
               bus.c_data = DW_OUT'($urandom);
            end
            tick();
            cycles++;
            if (rdy) begin
               drained[idx] = c_model[idx];
               if (ACCUM) c_model[idx] = '0;
               if (idx == NC-1) done = 1;
               idx++;
            end
         end
      end
      bus.c_out_ready = 1'b0;
      bus.c_we = 1'b0;
      if (abort_at < 0) begin
         checkOutput("drain_done", done, 1'b1);
         checkOutput("c_busy_end", bus.c_busy, 1'b0);
         checkOutput("c_out_valid_end", bus.c_out_valid, 1'b0);
      end
   endtask

   initial begin
      tile_a_t a0, a1, ay;
      tile_b_t b0;

      // T1: reset values
      applyReset();
      checkOutput("t1_ld_ready", bus.ld_ready, 1'b1);
      checkOutput("t1_act_valid", bus.act_valid, 1'b0);
      checkOutput("t1_rd_valid", bus.rd_valid, 1'b0);
      checkOutput("t1_rd_a", bus.rd_a, 0);
      checkOutput("t1_rd_b", bus.rd_b, 0);
      checkOutput("t1_c_busy", bus.c_busy, 1'b0);
      checkOutput("t1_c_out_valid", bus.c_out_valid, 1'b0);
      checkOutput("t1_c_out_data", bus.c_out_data, 0);
      checkOutput("t1_c_out_idx", bus.c_out_idx, 0);
      checkOutput("t1_c_out_last", bus.c_out_last, 1'b0);

      // T2: two loads fill both banks, then release swaps the active bank
      for (int i = 0; i < NA; i++) begin
         a0[i*DW_IN +: DW_IN] = DW_IN'(i + 1);
         a1[i*DW_IN +: DW_IN] = DW_IN'(8'h80 + i);
      end
      b0 = randTileB();
      applyStimulus(1, a0, b0, 0, 0, 0, 0);
      applyStimulus(1, a1, randTileB(), 0, 0, 0, 0);
      checkOutput("t2_ld_ready_full", bus.ld_ready, 1'b0);
      applyStimulus(1, randTileA(), randTileB(), 1, 3, 5, 0);
      checkOutput("t2_rd_a_bank0", bus.rd_a, 8'h04);
      applyStimulus(0, '0, '0, 0, 0, 0, 1);
      applyStimulus(0, '0, '0, 1, 3, 0, 0);
      checkOutput("t2_rd_a_bank1", bus.rd_a, 8'h83);

      // T3: load and release together at full_cnt=1
      applyReset();
      applyStimulus(1, randTileA(), randTileB(), 0, 0, 0, 0);
      for (int i = 0; i < NA; i++) ay[i*DW_IN +: DW_IN] = DW_IN'(8'h40 + i);
      applyStimulus(1, ay, randTileB(), 0, 0, 0, 1);
      checkOutput("t3_act_valid", bus.act_valid, 1'b1);
      checkOutput("t3_ld_ready", bus.ld_ready, 1'b1);
      applyStimulus(0, '0, '0, 1, 7, 2, 0);
      checkOutput("t3_new_bank", bus.rd_a, 8'h47);

      // Random load/read/release traffic
      applyReset();
      for (int n = 0; n < 300; n++) begin
         applyStimulus($urandom_range(0, 2) == 0, randTileA(), randTileB(),
                       1'($urandom_range(0, 1)), $urandom_range(0, NA-1), $urandom_range(0, NB-1),
                       $urandom_range(0, 3) == 0);
      end

      // T4: C[i]=i*3, drain with toggling ready and writes during drain
      applyReset();
      for (int i = 0; i < NC; i++) cWrite(i, DW_OUT'(i*3));
      drainRun(1, -1, 1);
      checkOutput("t4_beat15", drained[15], 45);
      drainRun(2, -1, 1);

      // T5: two writes to C[2], then two drains
      applyReset();
      cWrite(2, 16'h0010);
      cWrite(2, 16'h0010);
      drainRun(0, -1, 0);
      checkOutput("t5_beat2_first", drained[2], ACCUM ? 16'h0020 : 16'h0010);
      drainRun(0, -1, 0);
      checkOutput("t5_beat2_second", drained[2], ACCUM ? 16'h0000 : 16'h0010);

      // Random C writes and randomly stalled drains
      for (int r = 0; r < 3; r++) begin
         for (int n = 0; n < 20; n++) cWrite($urandom_range(0, NC-1), DW_OUT'($urandom));
         drainRun(2, -1, 1);
      end

      // T6: reset mid-drain at idx 5 with a tile loaded
      applyReset();
      applyStimulus(1, randTileA(), randTileB(), 0, 0, 0, 0);
      for (int i = 0; i < NC; i++) cWrite(i, DW_OUT'($urandom));
      drainRun(0, 5, 0);
      checkOutput("t6_idx_before", bus.c_out_idx, 5);
      rstn = 1'b0;
      #1;
      checkOutput("t6_c_busy", bus.c_busy, 1'b0);
      checkOutput("t6_c_out_valid", bus.c_out_valid, 1'b0);
      checkOutput("t6_ld_ready", bus.ld_ready, 1'b1);
      checkOutput("t6_act_valid", bus.act_valid, 1'b0);
      idleInputs();
      clearModel();
      @(posedge clk);
      #1 rstn = 1'b1;
      drainRun(0, -1, 0);
      checkOutput("t6_c_cleared", drained[7], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
